// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared widths, op/state encodings and helpers for the ex_div divider
package ex_div_pkg;

  localparam int DATA_BUS = 64;

  localparam logic [DATA_BUS-1:0] ZERO_DWORD = '0;
  localparam logic [DATA_BUS-1:0] ONES_DWORD = '1;
  localparam logic [DATA_BUS-1:0] WORD_MASK  = 64'h0000_0000_FFFF_FFFF;
  localparam logic [DATA_BUS-1:0] MIN_DWORD  = 64'h8000_0000_0000_0000;
  localparam logic [DATA_BUS-1:0] MIN_WORD   = 64'h0000_0000_8000_0000;

  // Divide-group op encodings as issued by ID/EX
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  // Iteration counts: one quotient bit per CALC cycle
  localparam logic [6:0] ITER_DWORD = 7'd64;
  localparam logic [6:0] ITER_WORD  = 7'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_t;

  // Word ops keep only bits [31:0]; the upper half is forced to zero
  function automatic logic [DATA_BUS-1:0] width_mask(input logic [DATA_BUS-1:0] x,
                                                     input logic                word);
    return word ? (x & WORD_MASK) : x;
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

  function automatic logic is_unsigned_op(input logic [1:0] op);
    return (op == DIV_OP_DIVU) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/ex_div_signfix.sv
// rtl/ex_div_signfix.sv - combinational sign restore and special-case override for ex_div results
module ex_div_signfix
  import ex_div_pkg::*;
(
  input  logic [DATA_BUS-1:0] i_quo,
  input  logic [DATA_BUS-1:0] i_rem,
  input  logic [DATA_BUS-1:0] i_dividend,
  input  logic                i_sign1,
  input  logic                i_sign2,
  input  logic [1:0]          i_op,
  input  logic                i_word,
  input  logic                i_div_zero,
  input  logic                i_ovf,
  output logic [DATA_BUS-1:0] o_res
);

  logic                w_signed;
  logic                w_rem_sel;
  logic [DATA_BUS-1:0] w_quo_s;
  logic [DATA_BUS-1:0] w_rem_s;
  logic [DATA_BUS-1:0] w_sel;

  assign w_signed  = is_signed_op(i_op) && !is_unsigned_op(i_op);
  assign w_rem_sel = is_rem_op(i_op);

  // Restore signs on the magnitudes, then let divide-by-zero / overflow win
  always_comb begin
    w_quo_s = i_quo;
    w_rem_s = i_rem;
    if (w_signed && (i_sign1 ^ i_sign2)) begin
      w_quo_s = ZERO_DWORD - i_quo;
    end
    if (w_signed && i_sign1) begin
      w_rem_s = ZERO_DWORD - i_rem;
    end
    if (i_div_zero) begin
      w_quo_s = ONES_DWORD;
      w_rem_s = i_dividend;
    end else if (i_ovf) begin
      w_quo_s = i_dividend;
      w_rem_s = ZERO_DWORD;
    end
    w_sel = w_rem_sel ? w_rem_s : w_quo_s;
    o_res = width_mask(w_sel, i_word);
  end

endmodule

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative radix-2 restoring divider for RV64M DIV/REM groups; option macro EX_DIV_EARLY_OUT_EN
module ex_div
  import ex_div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_div_valid_i,
  output logic                ex_div_ready_o,
  input  logic [1:0]          ex_div_op_i,
  input  logic                ex_div_inst_word_i,
  input  logic [DATA_BUS-1:0] ex_div_src1_data_i,
  input  logic [DATA_BUS-1:0] ex_div_src2_data_i,
  input  logic                ex_div_flush_i,
  output logic                ex_div_res_valid_o,
  input  logic                ex_div_res_ack_i,
  output logic [DATA_BUS-1:0] ex_div_res_data_o
);

  div_state_t          r_state;
  logic                r_ready;
  logic                r_res_valid;
  logic [DATA_BUS-1:0] r_res_data;
  logic [6:0]          r_cnt;
  logic [1:0]          r_op;
  logic                r_word;
  logic                r_sign1;
  logic                r_sign2;
  logic                r_div_zero;
  logic                r_ovf;
  logic [DATA_BUS-1:0] r_dividend;
  logic [DATA_BUS-1:0] r_divisor;
  logic [DATA_BUS-1:0] r_quo;
  logic [DATA_BUS-1:0] r_rem;

  // Request decode
  logic                w_signed_in;
  logic [DATA_BUS-1:0] w_a;
  logic [DATA_BUS-1:0] w_b;
  logic                w_sign1_in;
  logic                w_sign2_in;
  logic [DATA_BUS-1:0] w_a_mag;
  logic [DATA_BUS-1:0] w_b_mag;
  logic [DATA_BUS-1:0] w_min_neg;
  logic                w_div_zero_in;
  logic                w_ovf_in;
  logic                w_accept;

  // One restoring step
  logic [DATA_BUS:0]   w_rem_sh;
  logic                w_trial_ok;
  logic [DATA_BUS-1:0] w_rem_sub;
  logic [DATA_BUS-1:0] w_rem_nxt;
  logic [DATA_BUS-1:0] w_quo_nxt;

  // Sign-fix inputs and result
  logic [DATA_BUS-1:0] w_sf_dividend;
  logic                w_sf_sign1;
  logic                w_sf_sign2;
  logic [1:0]          w_sf_op;
  logic                w_sf_word;
  logic                w_sf_div_zero;
  logic                w_sf_ovf;
  logic [DATA_BUS-1:0] w_fix_res;

  assign w_signed_in = is_signed_op(ex_div_op_i);
  assign w_a         = width_mask(ex_div_src1_data_i, ex_div_inst_word_i);
  assign w_b         = width_mask(ex_div_src2_data_i, ex_div_inst_word_i);
  assign w_sign1_in  = w_signed_in &&
                       (ex_div_inst_word_i ? ex_div_src1_data_i[31] : ex_div_src1_data_i[63]);
  assign w_sign2_in  = w_signed_in &&
                       (ex_div_inst_word_i ? ex_div_src2_data_i[31] : ex_div_src2_data_i[63]);
  // Magnitudes are taken in the operating width so word ops stay 32-bit
  assign w_a_mag     = w_sign1_in ? width_mask(ZERO_DWORD - w_a, ex_div_inst_word_i) : w_a;
  assign w_b_mag     = w_sign2_in ? width_mask(ZERO_DWORD - w_b, ex_div_inst_word_i) : w_b;
  assign w_min_neg   = ex_div_inst_word_i ? MIN_WORD : MIN_DWORD;
  assign w_div_zero_in = (w_b == ZERO_DWORD);
  assign w_ovf_in    = w_signed_in && (w_a == w_min_neg) &&
                       (w_b == width_mask(ONES_DWORD, ex_div_inst_word_i));
  assign w_accept    = ex_div_valid_i && r_ready;

  // Shift {rem,quo} left one bit and trial-subtract; the 65-bit compare covers the carried-out bit
  assign w_rem_sh   = {r_rem, r_quo[DATA_BUS-1]};
  assign w_trial_ok = (w_rem_sh >= {1'b0, r_divisor});
  assign w_rem_sub  = w_rem_sh[DATA_BUS-1:0] - r_divisor;
  assign w_rem_nxt  = w_trial_ok ? w_rem_sub : w_rem_sh[DATA_BUS-1:0];
  assign w_quo_nxt  = {r_quo[DATA_BUS-2:0], w_trial_ok};

`ifdef EX_DIV_EARLY_OUT_EN
  // In IDLE the sign-fix sees the live request so special cases can finish at accept
  assign w_sf_dividend = (r_state == S_IDLE) ? w_a                : r_dividend;
  assign w_sf_sign1    = (r_state == S_IDLE) ? w_sign1_in         : r_sign1;
  assign w_sf_sign2    = (r_state == S_IDLE) ? w_sign2_in         : r_sign2;
  assign w_sf_op       = (r_state == S_IDLE) ? ex_div_op_i        : r_op;
  assign w_sf_word     = (r_state == S_IDLE) ? ex_div_inst_word_i : r_word;
  assign w_sf_div_zero = (r_state == S_IDLE) ? w_div_zero_in      : r_div_zero;
  assign w_sf_ovf      = (r_state == S_IDLE) ? w_ovf_in           : r_ovf;
`else
  assign w_sf_dividend = r_dividend;
  assign w_sf_sign1    = r_sign1;
  assign w_sf_sign2    = r_sign2;
  assign w_sf_op       = r_op;
  assign w_sf_word     = r_word;
  assign w_sf_div_zero = r_div_zero;
  assign w_sf_ovf      = r_ovf;
`endif

  ex_div_signfix u_signfix (
    .i_quo      (r_quo),
    .i_rem      (r_rem),
    .i_dividend (w_sf_dividend),
    .i_sign1    (w_sf_sign1),
    .i_sign2    (w_sf_sign2),
    .i_op       (w_sf_op),
    .i_word     (w_sf_word),
    .i_div_zero (w_sf_div_zero),
    .i_ovf      (w_sf_ovf),
    .o_res      (w_fix_res)
  );

  // Control FSM with datapath registers; flush beats ack and new requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= ZERO_DWORD;
      r_cnt       <= 7'd0;
      r_op        <= DIV_OP_DIV;
      r_word      <= 1'b0;
      r_sign1     <= 1'b0;
      r_sign2     <= 1'b0;
      r_div_zero  <= 1'b0;
      r_ovf       <= 1'b0;
      r_dividend  <= ZERO_DWORD;
      r_divisor   <= ZERO_DWORD;
      r_quo       <= ZERO_DWORD;
      r_rem       <= ZERO_DWORD;
    end else if (ex_div_flush_i) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_res_valid <= 1'b0;
      r_cnt       <= 7'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= ex_div_op_i;
            r_word     <= ex_div_inst_word_i;
            r_sign1    <= w_sign1_in;
            r_sign2    <= w_sign2_in;
            r_div_zero <= w_div_zero_in;
            r_ovf      <= w_ovf_in;
            r_dividend <= w_a;
            r_divisor  <= w_b_mag;
            r_rem      <= ZERO_DWORD;
            // Word dividends sit in the top half so 32 shifts leave the quotient in [31:0]
            r_quo      <= ex_div_inst_word_i ? {w_a_mag[31:0], 32'h0} : w_a_mag;
            r_cnt      <= ex_div_inst_word_i ? ITER_WORD : ITER_DWORD;
            r_ready    <= 1'b0;
`ifdef EX_DIV_EARLY_OUT_EN
            if (w_div_zero_in || w_ovf_in) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
              r_res_data  <= w_fix_res;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state    <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 7'd1;
          if (r_cnt == 7'd1) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_res_data  <= w_fix_res;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (ex_div_res_ack_i) begin
            r_res_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ex_div_ready_o     = r_ready;
  assign ex_div_res_valid_o = r_res_valid;
  assign ex_div_res_data_o  = r_res_data;

endmodule
